rv_fetch_aligner: RTL

Instruction fetch sequencer between the instruction memory port and the decompressing decoder. It issues word-aligned 32-bit fetches and buffers returned halfwords. It reassembles 16-bit compressed and 32-bit instructions, including 32-bit instructions that straddle a word boundary. It presents one instruction per handshake with its PC, and it handles PC redirects (jumps, branches, traps) by flushing the buffer and discarding in-flight data.

---
 rtl/rv_fetch_aligner.sv | 82 ++++++++
 1 files changed

// File: rtl/rv_fetch_aligner.sv
// rv_fetch_aligner: word-aligned fetch sequencer that realigns 16/32-bit instructions for the decoder
module rv_fetch_aligner #(
  parameter bit          rv64     = 1'b1,
  parameter logic [63:0] reset_pc = 64'h0,
  localparam int         XLEN     = rv64 ? 64 : 32
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_is_compressed
);
  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_e;
  localparam logic [XLEN-1:0] RST_PC = reset_pc[XLEN-1:0];
  state_e state_q, state_d;
  logic [3:0][15:0] hb_q, hb_d, hb_s;
  logic [2:0] count_q, count_d, cnt_s, n_cons, n_app;
  logic [XLEN-1:0] pc_q, pc_d, fetch_addr_q, fetch_addr_d;
  logic drop_q, drop_d, is_c, fire, cons, app;
  logic [15:0] a0;
  assign is_c = hb_q[0][1:0] != 2'b11;
  assign inst_valid = reset_n & (count_q >= 3'd2 | (count_q == 3'd1 & is_c));
  assign inst = is_c ? {16'h0, hb_q[0]} : {hb_q[1], hb_q[0]};
  assign inst_pc = pc_q;
  assign inst_is_compressed = ~&inst[1:0];
  assign mem_req_valid = reset_n & state_q == IDLE & count_q <= 3'd2 & !redirect_valid;
  assign mem_req_addr = fetch_addr_q;
  assign fire = mem_req_valid & mem_req_ready;
  assign cons = inst_valid & inst_ready & !redirect_valid;
  assign app = state_q == WAIT & mem_resp_valid & !redirect_valid;
  always_comb begin
    n_cons = cons ? (is_c ? 3'd1 : 3'd2) : 3'd0;
    n_app = app ? (drop_q ? 3'd1 : 3'd2) : 3'd0;
    a0 = drop_q ? mem_resp_data[31:16] : mem_resp_data[15:0];
    cnt_s = count_q - n_cons;
    hb_s = hb_q >> {n_cons, 4'd0};
    hb_d = hb_s;
    for (int i = 0; i < 4; i++) begin
      if (n_app != 3'd0 && 3'(i) == cnt_s) hb_d[i] = a0;
      if (n_app == 3'd2 && 3'(i) == cnt_s + 3'd1) hb_d[i] = mem_resp_data[31:16];
    end
    count_d = cnt_s + n_app;
    pc_d = pc_q + XLEN'({n_cons, 1'b0});
    fetch_addr_d = fire ? fetch_addr_q + XLEN'(4) : fetch_addr_q;
    drop_d = app ? 1'b0 : drop_q;
    state_d = state_q == IDLE ? (fire ? WAIT : IDLE)
            : mem_resp_valid ? IDLE
            : (state_q == WAIT && redirect_valid) ? WAIT_DISCARD : state_q;
    if (redirect_valid) begin
      count_d = 3'd0;
      pc_d = redirect_pc & ~XLEN'(1);
      fetch_addr_d = redirect_pc & ~XLEN'(3);
      drop_d = redirect_pc[1];
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hb_q <= '0;
      count_q <= 3'd0;
      pc_q <= RST_PC;
      fetch_addr_q <= RST_PC & ~XLEN'(3);
      drop_q <= RST_PC[1];
    end else begin
      state_q <= state_d;
      hb_q <= hb_d;
      count_q <= count_d;
      pc_q <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      drop_q <= drop_d;
    end
  end
endmodule
